// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: sequencer states and request size codes.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_access_unit.sv
// Splits byte/word load-store requests into single-byte memory cycles
// and returns one response pulse per request.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    output logic [15:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_write_data,
    output logic                  mem_write_enable,
    input  logic [7:0]            mem_read_data
);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic                  size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           cap_q, cap_d;
    logic [15:0]           rdata_q, rdata_d;

    logic                  hi_lane;
    logic [7:0]            lane_byte;
    logic [15:0]           cap_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    // The second byte cycle always handles the lane the first one did not.
    always_comb begin
        if (state_q == BYTE1) begin
            hi_lane = !BIG_ENDIAN;
        end else begin
            hi_lane = (size_q == SIZE_WORD) && BIG_ENDIAN;
        end
        lane_byte = hi_lane ? wdata_q[15:8] : wdata_q[7:0];
        cap_next  = cap_q;
        if (hi_lane) begin
            cap_next[15:8] = mem_read_data;
        end else begin
            cap_next[7:0] = mem_read_data;
        end
    end

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        cap_d            = cap_q;
        rdata_d          = rdata_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = '0;
        mem_write_data   = 8'h00;
        mem_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cap_d   = '0;
                    state_d = BYTE0;
                end
            end
            BYTE0, BYTE1: begin
                mem_address = (state_q == BYTE1) ? addr_q + ADDR_WIDTH'(1) : addr_q;
                if (write_q) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = lane_byte;
                end else begin
                    cap_d = cap_next;
                end
                if (state_q == BYTE0 && size_q == SIZE_WORD) begin
                    state_d = BYTE1;
                end else begin
                    // Result register only changes as the access completes.
                    rdata_d = write_q ? 16'h0000 : cap_next;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a response scoreboard and memory write monitor.
module tb_mem_access_unit;

    typedef struct packed {
        logic [15:0] rdata;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        req_valid = 1'b0, req_write = 1'b0, req_size = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, mem_write_enable;
    logic [15:0] resp_rdata, mem_address;
    logic [7:0]  mem_write_data, mem_read_data;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_size = 1'b0;
    logic [15:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_resp_valid, b_mem_write_enable;
    logic [15:0] b_resp_rdata, b_mem_address;
    logic [7:0]  b_mem_write_data, b_mem_read_data;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  bmem [0:65535];

    exp_t        exp_q[$];
    logic [23:0] wexp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    mem_access_unit #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
        .mem_write_enable(b_mem_write_enable), .mem_read_data(b_mem_read_data)
    );

    assign mem_read_data   = mem[mem_address];
    assign b_mem_read_data = bmem[b_mem_address];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        if (b_mem_write_enable) bmem[b_mem_address] <= b_mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every memory write and every response must have been predicted.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write_enable) begin
                n_cmp++;
                assert (wexp_q.size() > 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_write observed=%h_%h expected=none", mem_address, mem_write_data);
                end
                if (wexp_q.size() > 0) chk("mem_write", {mem_address, mem_write_data}, wexp_q.pop_front());
            end
            if (resp_valid) begin
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_resp observed=%h expected=none", resp_rdata);
                end
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_cycle", cyc, e.due);
                    $display("resp rdata=%h cycle=%0d", resp_rdata, cyc);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp, input bit want_resp, output int acc);
        bit got;
        got = 1'b0;
        req_write = w; req_size = s; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        acc = cyc;
        n_cmp++;
        assert (got) else begin
            n_bad++;
            $error("FAIL accept_timeout observed=no_accept expected=accept addr=%h", a);
        end
        chk("ready_low_busy", req_ready, 1'b0);
        if (want_resp) exp_q.push_back('{rdata: exp, due: acc + (s ? 2 : 1)});
        $display("req w=%0d s=%0d addr=%h wdata=%h accepted cycle=%0d", w, s, a, d, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (exp_q.size() > 0 || wexp_q.size() > 0); k++) @(posedge clk);
        #1;
        chk("drain_resp_q", exp_q.size(), 0);
        chk("drain_write_q", wexp_q.size(), 0);
    endtask

    initial begin
        int a0, a1, a2, a3, a4, bacc, bresp;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            bmem[i] = 8'h00;
        end
        mem[16'h000A] = 8'h34; mem[16'h000B] = 8'h12; mem[16'h0003] = 8'h77;
        bmem[16'h000A] = 8'h34; bmem[16'h000B] = 8'h12;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 16'h0000);
        chk("rst_mem_address", mem_address, 16'h0000);
        chk("rst_mem_wdata", mem_write_data, 8'h00);
        chk("rst_mem_we", mem_write_enable, 1'b0);
        reset_n = 1'b1;

        // Byte store
        wexp_q.push_back({16'h0005, 8'hAB});
        issue(1'b1, 1'b0, 16'h0005, 16'h12AB, 16'h0000, 1'b1, a0);
        req_valid = 1'b0;
        drain();
        chk("t1_mem05", mem[16'h0005], 8'hAB);

        // Word load, address sequence
        issue(1'b0, 1'b1, 16'h000A, 16'h0000, 16'h1234, 1'b1, a0);
        req_valid = 1'b0;
        chk("t2_addr0", mem_address, 16'h000A);
        chk("t2_we0", mem_write_enable, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_addr1", mem_address, 16'h000B);
        drain();
        chk("t2_rdata_hold", resp_rdata, 16'h1234);

        // Big-endian instance word load
        b_req_write = 1'b0; b_req_size = 1'b1; b_req_addr = 16'h000A; b_req_valid = 1'b1;
        @(posedge clk);
        #1;
        bacc = cyc;
        b_req_valid = 1'b0;
        bresp = -1;
        for (int k = 0; k < 10 && bresp < 0; k++) begin
            @(negedge clk);
            if (b_resp_valid) bresp = cyc;
        end
        chk("t2_be_cycle", bresp, bacc + 2);
        chk("t2_be_rdata", b_resp_rdata, 16'h3412);
        $display("be resp rdata=%h cycle=%0d", b_resp_rdata, bresp);
        @(posedge clk);
        #1;

        // Odd-address word store then load
        wexp_q.push_back({16'h0013, 8'hEF});
        wexp_q.push_back({16'h0014, 8'hBE});
        issue(1'b1, 1'b1, 16'h0013, 16'hBEEF, 16'h0000, 1'b1, a0);
        issue(1'b0, 1'b1, 16'h0013, 16'h0000, 16'hBEEF, 1'b1, a1);
        req_valid = 1'b0;
        drain();
        chk("t3_mem13", mem[16'h0013], 8'hEF);
        chk("t3_mem14", mem[16'h0014], 8'hBE);

        // Address wrap
        wexp_q.push_back({16'hFFFF, 8'hFE});
        wexp_q.push_back({16'h0000, 8'hCA});
        issue(1'b1, 1'b1, 16'hFFFF, 16'hCAFE, 16'h0000, 1'b1, a0);
        issue(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00CA, 1'b1, a1);
        req_valid = 1'b0;
        drain();
        chk("t4_memFFFF", mem[16'hFFFF], 8'hFE);

        // Continuous valid, mixed requests
        wexp_q.push_back({16'h0020, 8'h77});
        wexp_q.push_back({16'h0030, 8'h22});
        wexp_q.push_back({16'h0031, 8'h11});
        issue(1'b1, 1'b0, 16'h0020, 16'h9977, 16'h0000, 1'b1, a0);
        issue(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0077, 1'b1, a1);
        issue(1'b0, 1'b1, 16'h000B, 16'h0000, 16'h0012, 1'b1, a2);
        issue(1'b1, 1'b1, 16'h0030, 16'h1122, 16'h0000, 1'b1, a3);
        issue(1'b0, 1'b1, 16'h0030, 16'h0000, 16'h1122, 1'b1, a4);
        req_valid = 1'b0;
        chk("t5_space_byte_st", a1 - a0, 3);
        chk("t5_space_byte_ld", a2 - a1, 3);
        chk("t5_space_word_ld", a3 - a2, 4);
        chk("t5_space_word_st", a4 - a3, 4);
        drain();

        // Reset during second byte of a word store
        wexp_q.push_back({16'h0002, 8'h66});
        issue(1'b1, 1'b1, 16'h0002, 16'h5566, 16'h0000, 1'b0, a0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_byte1_addr", mem_address, 16'h0003);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_addr", mem_address, 16'h0000);
        chk("t6_rst_we", mem_write_enable, 1'b0);
        chk("t6_rst_wdata", mem_write_data, 8'h00);
        chk("t6_rst_resp", resp_valid, 1'b0);
        chk("t6_rst_rdata", resp_rdata, 16'h0000);
        chk("t6_rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_mem02", mem[16'h0002], 8'h66);
        chk("t6_mem03", mem[16'h0003], 8'h77);
        chk("t6_ready", req_ready, 1'b1);
        issue(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h7766, 1'b1, a0);
        req_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
